butterfly_pipe: RTL

//  Pipelined radix-2 butterfly: y0 = x0+x1, y1 = x0-x1 on complex samples, per-sample scale-by-2 or unscaled.

---
 rtl/butterfly_pkg.sv | 18 +
 rtl/bf_round_sat.sv | 40 ++++
 rtl/butterfly_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// Shared types and helpers for the pipelined radix-2 butterfly.
package butterfly_pkg;

    typedef enum logic {
        BF_SCALE_NONE = 1'b0,
        BF_SCALE_HALF = 1'b1
    } bf_scale_e;

    // Signed range limits of a w-bit two's complement value (w < 32).
    function automatic logic signed [31:0] bf_smax(input int unsigned w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] bf_smin(input int unsigned w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/bf_round_sat.sv
// One-component output stage: scale-by-2 with optional rounding, or unscaled with overflow detect.
// BUTTERFLY_SATURATE_EN clamps unscaled overflows instead of wrapping.
module bf_round_sat
    import butterfly_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RH    = 0
) (
    input  logic signed [WIDTH:0]   s,
    input  bf_scale_e               scale,
    output logic signed [WIDTH-1:0] r,
    output logic                    ovf
);

`ifdef BUTTERFLY_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(bf_smax(WIDTH));
    localparam logic signed [WIDTH-1:0] SMIN = WIDTH'(bf_smin(WIDTH));
`endif

    logic [WIDTH:0] rnd;
    logic           wrap_ovf;

    assign rnd      = s + (WIDTH + 1)'(RH);
    assign wrap_ovf = s[WIDTH] ^ s[WIDTH-1];

    always_comb begin
        r   = s[WIDTH-1:0];
        ovf = 1'b0;
        if (scale == BF_SCALE_HALF) begin
            r = WIDTH'(rnd >> 1);
        end else begin
            ovf = wrap_ovf;
`ifdef BUTTERFLY_SATURATE_EN
            if (wrap_ovf)
                r = s[WIDTH] ? SMIN : SMAX;
`endif
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Two-stage pipelined radix-2 complex butterfly with valid/ready flow control and overflow flags.
// Optional BUTTERFLY_SATURATE_EN: unscaled overflows saturate rather than wrap.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RH    = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_scale,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] x0_real,
    input  logic signed [WIDTH-1:0] x0_imag,
    input  logic signed [WIDTH-1:0] x1_real,
    input  logic signed [WIDTH-1:0] x1_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y0_real,
    output logic signed [WIDTH-1:0] y0_imag,
    output logic signed [WIDTH-1:0] y1_real,
    output logic signed [WIDTH-1:0] y1_imag,
    output logic                    out_last,
    output logic                    out_ovf,
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
);

    logic                  s1_valid;
    logic                  s1_last;
    bf_scale_e             s1_scale;
    logic signed [WIDTH:0] s1_sum_r, s1_sum_i, s1_dif_r, s1_dif_i;
    logic                  s1_adv, s2_adv;

    logic signed [WIDTH-1:0] r_y0r, r_y0i, r_y1r, r_y1i;
    logic                    o_y0r, o_y0i, o_y1r, o_y1i;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: full-precision add/sub, sign-extended to WIDTH+1 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_scale <= BF_SCALE_NONE;
            s1_sum_r <= '0;
            s1_sum_i <= '0;
            s1_dif_r <= '0;
            s1_dif_i <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last  <= in_last;
                s1_scale <= bf_scale_e'(in_scale);
                s1_sum_r <= {x0_real[WIDTH-1], x0_real} + {x1_real[WIDTH-1], x1_real};
                s1_sum_i <= {x0_imag[WIDTH-1], x0_imag} + {x1_imag[WIDTH-1], x1_imag};
                s1_dif_r <= {x0_real[WIDTH-1], x0_real} - {x1_real[WIDTH-1], x1_real};
                s1_dif_i <= {x0_imag[WIDTH-1], x0_imag} - {x1_imag[WIDTH-1], x1_imag};
            end
        end
    end

    bf_round_sat #(.WIDTH(WIDTH), .RH(RH)) u_y0r (.s(s1_sum_r), .scale(s1_scale), .r(r_y0r), .ovf(o_y0r));
    bf_round_sat #(.WIDTH(WIDTH), .RH(RH)) u_y0i (.s(s1_sum_i), .scale(s1_scale), .r(r_y0i), .ovf(o_y0i));
    bf_round_sat #(.WIDTH(WIDTH), .RH(RH)) u_y1r (.s(s1_dif_r), .scale(s1_scale), .r(r_y1r), .ovf(o_y1r));
    bf_round_sat #(.WIDTH(WIDTH), .RH(RH)) u_y1i (.s(s1_dif_i), .scale(s1_scale), .r(r_y1i), .ovf(o_y1i));

    // Stage 2: output register; the sticky flag sees the transfer being completed this edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
            y0_real    <= '0;
            y0_imag    <= '0;
            y1_real    <= '0;
            y1_imag    <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_last <= s1_last;
                    out_ovf  <= o_y0r | o_y0i | o_y1r | o_y1i;
                    y0_real  <= r_y0r;
                    y0_imag  <= r_y0i;
                    y1_real  <= r_y1r;
                    y1_imag  <= r_y1i;
                end
            end
            if (out_valid && out_ready && out_ovf)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;
        end
    end

endmodule
